// File: rtl/output_accumulator.sv
// Reduces per-lane PE partial sums, accumulates them over a multi-beat group with optional bias preload, and emits one shifted, saturated vector per group. OUTPUT_RELU_EN clamps negative results to zero.
// Latency: a beat accepted on edge N is reduced at N and accumulated at N+1; a last beat presents out_valid after N+1.
// Backpressure: a held, unaccepted output stalls the whole pipeline; in_ready = ~out_valid | out_ready, so no beat is lost or duplicated.
module output_accumulator #(
    parameter int LANES  = 16,
    parameter int TERMS  = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*TERMS*PSUM_W-1:0] in_psum,
    input  logic                          in_bias_en,
    input  logic [LANES*OUT_W-1:0]        in_bias_data,
    input  logic                          in_accum_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_W-1:0]        out_sum,
    output logic [LANES-1:0]              out_sat
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Output clipping bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    function automatic logic [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
        return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

    function automatic logic [ACC_W-1:0] sext_bias(input logic [OUT_W-1:0] b);
        return {{(ACC_W-OUT_W){b[OUT_W-1]}}, b};
    endfunction

    // Global stage enable: everything advances unless a held result is refused.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage 1 signals
    logic [ACC_W-1:0]       red_d  [LANES];
    logic [ACC_W-1:0]       s1_red [LANES];
    logic                   s1_vld;
    logic                   s1_bias_en;
    logic                   s1_done;
    logic [LANES*OUT_W-1:0] s1_bias;

    // Stage 2 signals
    state_t                  state_q;
    state_t                  state_d;
    logic                    acc_ld;
    logic                    out_ld;
    logic [ACC_W-1:0]        acc_q [LANES];
    logic [ACC_W-1:0]        acc_d [LANES];
    logic [ACC_W-1:0]        bias_sh;
    logic signed [ACC_W-1:0] v_d   [LANES];
    logic [LANES*OUT_W-1:0]  sum_d;
    logic [LANES-1:0]        sat_d;

    // Adder tree per lane: signed sum of all terms at accumulator width.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            red_d[l] = '0;
            for (int t = 0; t < TERMS; t++) begin
                red_d[l] = red_d[l] + sext_psum(in_psum[(l*TERMS+t)*PSUM_W +: PSUM_W]);
            end
        end
    end

    // Stage 1 register: capture reduction and group sideband on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_bias_en <= 1'b0;
            s1_done    <= 1'b0;
            s1_bias    <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_red[l] <= '0;
            end
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_bias_en <= in_bias_en;
                s1_done    <= in_accum_done;
                s1_bias    <= in_bias_data;
                for (int l = 0; l < LANES; l++) begin
                    s1_red[l] <= red_d[l];
                end
            end
        end
    end

    // Group FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Group FSM next state plus accumulator/output load strobes.
    always_comb begin
        state_d = state_q;
        acc_ld  = 1'b0;
        out_ld  = 1'b0;
        if (en && s1_vld) begin
            acc_ld = 1'b1;
            out_ld = s1_done;
            case (state_q)
                ST_IDLE:  if (!s1_done) state_d = ST_ACCUM;
                ST_ACCUM: if (s1_done)  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next accumulator value: first beat seeds with reduction plus pre-shifted bias, later beats add.
    always_comb begin
        bias_sh = '0;
        for (int l = 0; l < LANES; l++) begin
            if (state_q == ST_IDLE) begin
                bias_sh  = s1_bias_en ? (sext_bias(s1_bias[l*OUT_W +: OUT_W]) << SHIFT) : '0;
                acc_d[l] = s1_red[l] + bias_sh;
            end else begin
                acc_d[l] = acc_q[l] + s1_red[l];
            end
        end
    end

    // Accumulator register; wraps modulo 2^ACC_W by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else if (acc_ld) begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

    // Requantise: arithmetic shift (truncating), optional ReLU, then clip to OUT_W with flag.
    always_comb begin
        sum_d = '0;
        sat_d = '0;
        for (int l = 0; l < LANES; l++) begin
            v_d[l] = $signed(acc_d[l]) >>> SHIFT;
`ifdef OUTPUT_RELU_EN
            if (v_d[l] < 0) begin
                v_d[l] = '0;
            end
`endif
            if (v_d[l] > MAX_V) begin
                sum_d[l*OUT_W +: OUT_W] = MAX_V[OUT_W-1:0];
                sat_d[l]                = 1'b1;
            end else if (v_d[l] < MIN_V) begin
                sum_d[l*OUT_W +: OUT_W] = MIN_V[OUT_W-1:0];
                sat_d[l]                = 1'b1;
            end else begin
                sum_d[l*OUT_W +: OUT_W] = v_d[l][OUT_W-1:0];
            end
        end
    end

    // Output register: result only changes on load; valid drops once consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= '0;
        end else if (en) begin
            out_valid <= out_ld;
            if (out_ld) begin
                out_sum <= sum_d;
                out_sat <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_output_accumulator.sv
// Directed bench for output_accumulator: scoreboard of expected vectors checked at each output handshake.
module tb_output_accumulator;

    localparam int LANES  = 16;
    localparam int TERMS  = 16;
    localparam int PSUM_W = 16;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rst_n;
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*TERMS*PSUM_W-1:0] in_psum;
    logic                          in_bias_en;
    logic [LANES*OUT_W-1:0]        in_bias_data;
    logic                          in_accum_done;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*OUT_W-1:0]        out_sum;
    logic [LANES-1:0]              out_sat;

    logic                          s4_in_valid;
    logic                          s4_in_ready;
    logic [LANES*TERMS*PSUM_W-1:0] s4_in_psum;
    logic                          s4_in_bias_en;
    logic [LANES*OUT_W-1:0]        s4_in_bias_data;
    logic                          s4_in_accum_done;
    logic                          s4_out_valid;
    logic                          s4_out_ready;
    logic [LANES*OUT_W-1:0]        s4_out_sum;
    logic [LANES-1:0]              s4_out_sat;

    output_accumulator #(
        .LANES(LANES), .TERMS(TERMS), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .in_bias_en(in_bias_en), .in_bias_data(in_bias_data), .in_accum_done(in_accum_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat)
    );

    output_accumulator #(
        .LANES(LANES), .TERMS(TERMS), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(4)
    ) u_dut_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_psum(s4_in_psum),
        .in_bias_en(s4_in_bias_en), .in_bias_data(s4_in_bias_data), .in_accum_done(s4_in_accum_done),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_sum(s4_out_sum), .out_sat(s4_out_sat)
    );

    typedef struct packed {
        logic [LANES*OUT_W-1:0] sum;
        logic [LANES-1:0]       sat;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   m_acc [LANES];
    bit   m_in_group = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] rep16(input logic [15:0] v);
        logic [255:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*16 +: 16] = v;
        return r;
    endfunction

    // Reference model: psum(l,t) = val + ofs*(l+t), bias(l) = bval + ofs*l, SHIFT = 0.
    task automatic model_beat(input int val, input int ofs, input bit ben, input int bval, input bit done);
        exp_t e;
        int   red;
        int   v;
        e.sum = '0;
        e.sat = '0;
        for (int l = 0; l < LANES; l++) begin
            red = 0;
            for (int t = 0; t < TERMS; t++) red += val + ofs*(l+t);
            if (!m_in_group) m_acc[l] = red + (ben ? (bval + ofs*l) : 0);
            else             m_acc[l] = m_acc[l] + red;
            if (done) begin
                v = m_acc[l];
`ifdef OUTPUT_RELU_EN
                if (v < 0) v = 0;
`endif
                if (v > 32767) begin
                    e.sum[l*16 +: 16] = 16'h7FFF;
                    e.sat[l]          = 1'b1;
                end else if (v < -32768) begin
                    e.sum[l*16 +: 16] = 16'h8000;
                    e.sat[l]          = 1'b1;
                end else begin
                    e.sum[l*16 +: 16] = v[15:0];
                end
            end
        end
        if (done) sb_q.push_back(e);
        m_in_group = !done;
    endtask

    task automatic drive_inputs(input int val, input int ofs, input bit ben, input int bval, input bit done);
        int p;
        for (int l = 0; l < LANES; l++) begin
            for (int t = 0; t < TERMS; t++) begin
                p = val + ofs*(l+t);
                in_psum[(l*TERMS+t)*PSUM_W +: PSUM_W] = p[15:0];
            end
            p = bval + ofs*l;
            in_bias_data[l*OUT_W +: OUT_W] = p[15:0];
        end
        in_bias_en    = ben;
        in_accum_done = done;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input int val, input int ofs, input bit ben, input int bval, input bit done);
        bit ok;
        ok = 1'b0;
        drive_inputs(val, ofs, ben, bval, done);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                model_beat(val, ofs, ben, bval, done);
                @(posedge clk);
                #1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("beat_accepted", {255'b0, ok}, 256'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drained", {224'b0, 32'(sb_q.size()), 1'b0} >> 1, 256'd0);
        chk("drained_valid", {255'b0, out_valid}, 256'd0);
    endtask

    task automatic s4_group(input int val, input bit ben, input int bval, input logic [15:0] lane_exp);
        int  p;
        bit  seen;
        seen = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int t = 0; t < TERMS; t++) begin
                p = val;
                s4_in_psum[(l*TERMS+t)*PSUM_W +: PSUM_W] = p[15:0];
            end
            p = bval;
            s4_in_bias_data[l*OUT_W +: OUT_W] = p[15:0];
        end
        s4_in_bias_en = ben;
        s4_in_valid   = 1'b1;
        chk("s4_in_ready", {255'b0, s4_in_ready}, 256'd1);
        @(posedge clk);
        #1;
        s4_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s4_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("s4_out_seen", {255'b0, seen}, 256'd1);
        chk("s4_sum", s4_out_sum, rep16(lane_exp));
        chk("s4_sat", {240'b0, s4_out_sat}, 256'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completed output handshake pops one expected vector.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", {255'b0, out_valid}, 256'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_sum", out_sum, mon_e.sum);
                chk("sb_sat", {240'b0, out_sat}, {240'b0, mon_e.sat});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        in_valid         = 1'b0;
        in_psum          = '0;
        in_bias_en       = 1'b0;
        in_bias_data     = '0;
        in_accum_done    = 1'b0;
        out_ready        = 1'b1;
        s4_in_valid      = 1'b0;
        s4_in_psum       = '0;
        s4_in_bias_en    = 1'b0;
        s4_in_bias_data  = '0;
        s4_in_accum_done = 1'b1;
        s4_out_ready     = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_out_sum", out_sum, 256'd0);
        chk("rst_out_sat", {240'b0, out_sat}, 256'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {255'b0, in_ready}, 256'd1);

        // Single-beat group with bias: 16*1 + 5 = 21, valid two edges after accept
        send_beat(1, 0, 1'b1, 5, 1'b1);
        chk("lat_not_yet", {255'b0, out_valid}, 256'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {255'b0, out_valid}, 256'd1);
        chk("single_sum", out_sum, rep16(16'h0015));
        drain();

        // Three-beat group, bias on later beats ignored: 3*32 = 96
        send_beat(2, 0, 1'b0, 0, 1'b0);
        send_beat(2, 0, 1'b1, 100, 1'b0);
        send_beat(2, 0, 1'b1, 100, 1'b1);
        drain();

        // Back-to-back single-beat groups: consume and load on one edge
        send_beat(1, 0, 1'b0, 0, 1'b1);
        send_beat(2, 0, 1'b0, 0, 1'b1);
        chk("b2b_first_valid", {255'b0, out_valid}, 256'd1);
        @(posedge clk);
        #1;
        chk("b2b_second_valid", {255'b0, out_valid}, 256'd1);
        chk("b2b_second_sum", out_sum, rep16(16'd32));
        drain();

        // Positive and negative saturation
        for (int b = 0; b < 4; b++) send_beat(32767, 0, 1'b0, 0, b == 3);
        for (int b = 0; b < 4; b++) send_beat(-32768, 0, 1'b0, 0, b == 3);
        drain();

        // Lane/term-dependent values with signed bias
        send_beat(-5, 3, 1'b1, -7, 1'b0);
        send_beat(10, -2, 1'b0, 0, 1'b1);
        drain();

        // Negative result: 0xFFF0 signed, 0 with ReLU
        send_beat(-1, 0, 1'b0, 0, 1'b1);
        drain();

        // Backpressure: group 1 held while group 2 streams in behind it
        out_ready = 1'b0;
        send_beat(3, 0, 1'b0, 0, 1'b1);
        send_beat(4, 0, 1'b0, 0, 1'b0);
        fork
            send_beat(4, 0, 1'b0, 0, 1'b1);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", {255'b0, in_ready}, 256'd0);
                    chk("bp_hold_valid", {255'b0, out_valid}, 256'd1);
                    chk("bp_hold_sum", out_sum, rep16(16'd48));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a four-beat group
        send_beat(2, 0, 1'b0, 0, 1'b0);
        send_beat(2, 0, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {255'b0, out_valid}, 256'd0);
        chk("midrst_sum", out_sum, 256'd0);
        chk("midrst_sat", {240'b0, out_sat}, 256'd0);
        sb_q.delete();
        m_in_group = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(0, 0, 1'b1, 3, 1'b1);
        @(posedge clk);
        #1;
        chk("postrst_sum", out_sum, rep16(16'd3));
        drain();

        // SHIFT = 4 instance: 16 >>> 4 = 1; with bias 2 preloaded as 32: 48 >>> 4 = 3
        s4_group(1, 1'b0, 0, 16'd1);
        s4_group(1, 1'b1, 2, 16'd3);

        chk("sb_final_empty", 256'(sb_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
